// File: rtl/activation_unit_if.sv
// Handshake/data bundle for activation_unit; lr_sat_count_out is present only
// when ACT_SAT_COUNT_EN is defined.
interface activation_unit_if #(
    parameter int unsigned N_COLS = 4,
    parameter int unsigned DATA_W = 16
);
    logic                       lr_cfg_wr_in;
    logic [1:0]                 lr_mode_in;
    logic [DATA_W-1:0]          lr_leak_factor_in;
    logic [N_COLS-1:0]          lr_valid_in;
    logic [N_COLS*DATA_W-1:0]   lr_data_in;
    logic                       lr_ready_out;
    logic [N_COLS-1:0]          lr_valid_out;
    logic [N_COLS*DATA_W-1:0]   lr_data_out;
    logic                       lr_cfg_pending_out;
`ifdef ACT_SAT_COUNT_EN
    logic [31:0]                lr_sat_count_out;

    modport slave (
        input  lr_cfg_wr_in, lr_mode_in, lr_leak_factor_in, lr_valid_in, lr_data_in,
        output lr_ready_out, lr_valid_out, lr_data_out, lr_cfg_pending_out, lr_sat_count_out
    );
    modport master (
        output lr_cfg_wr_in, lr_mode_in, lr_leak_factor_in, lr_valid_in, lr_data_in,
        input  lr_ready_out, lr_valid_out, lr_data_out, lr_cfg_pending_out, lr_sat_count_out
    );
`else
    modport slave (
        input  lr_cfg_wr_in, lr_mode_in, lr_leak_factor_in, lr_valid_in, lr_data_in,
        output lr_ready_out, lr_valid_out, lr_data_out, lr_cfg_pending_out
    );
    modport master (
        output lr_cfg_wr_in, lr_mode_in, lr_leak_factor_in, lr_valid_in, lr_data_in,
        input  lr_ready_out, lr_valid_out, lr_data_out, lr_cfg_pending_out
    );
`endif
endinterface

// File: rtl/activation_unit.sv
// Two-stage per-lane passthrough / ReLU / leaky-ReLU with drain-synchronised config.
// Optional saturation event counter enabled by ACT_SAT_COUNT_EN.
module activation_unit #(
    parameter int unsigned N_COLS = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 8
) (
    input logic              clk,
    input logic              rst,
    activation_unit_if.slave lr
);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic signed [PROD_W-1:0] ROUND = PROD_W'(1) << (FRAC_W - 1);
    localparam logic signed [PROD_W-1:0] MAX_Y = (PROD_W'(1) << (DATA_W - 1)) - PROD_W'(1);
    localparam logic signed [PROD_W-1:0] MIN_Y = -(PROD_W'(1) << (DATA_W - 1));

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_RELU  = 2'b01,
        MODE_LEAKY = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    mode_e                     act_mode_q, act_mode_d, shd_mode_q, shd_mode_d;
    logic signed [DATA_W-1:0]  act_leak_q, act_leak_d, shd_leak_q, shd_leak_d;
    logic                      cfg_pending_q, cfg_pending_d;
    logic                      ready, apply;
    logic [N_COLS-1:0]         accept;

    logic [N_COLS-1:0]         s1_valid_q, s1_valid_d;
    logic signed [DATA_W-1:0]  s1_x_q    [N_COLS];
    logic signed [DATA_W-1:0]  s1_x_d    [N_COLS];
    logic signed [PROD_W-1:0]  s1_prod_q [N_COLS];
    logic signed [PROD_W-1:0]  s1_prod_d [N_COLS];
    mode_e                     s1_mode_q, s1_mode_d;

    logic signed [PROD_W-1:0]  lane_rnd  [N_COLS];
    logic [N_COLS-1:0]         lane_neg, lane_sat_hi, lane_sat_lo;

    logic [N_COLS-1:0]         s2_valid_q, s2_valid_d;
    logic signed [DATA_W-1:0]  s2_data_q [N_COLS];
    logic signed [DATA_W-1:0]  s2_data_d [N_COLS];

    // Config only moves shadow -> active once both stages are empty, so a
    // beat never sees a configuration change between its two stages.
    always_comb begin
        apply         = cfg_pending_q && (s1_valid_q == '0) && (s2_valid_q == '0);
        act_mode_d    = act_mode_q;
        act_leak_d    = act_leak_q;
        shd_mode_d    = shd_mode_q;
        shd_leak_d    = shd_leak_q;
        cfg_pending_d = cfg_pending_q;
        if (apply) begin
            act_mode_d    = shd_mode_q;
            act_leak_d    = shd_leak_q;
            cfg_pending_d = 1'b0;
        end
        if (lr.lr_cfg_wr_in) begin
            shd_mode_d    = mode_e'(lr.lr_mode_in);
            shd_leak_d    = lr.lr_leak_factor_in;
            cfg_pending_d = 1'b1;
        end
    end

    always_comb begin
        ready      = !cfg_pending_q;
        accept     = lr.lr_valid_in & {N_COLS{ready}};
        s1_valid_d = accept;
        s1_mode_d  = act_mode_q;
        for (int unsigned i = 0; i < N_COLS; i++) begin
            s1_x_d[i]    = accept[i] ? lr.lr_data_in[i*DATA_W +: DATA_W] : '0;
            s1_prod_d[i] = PROD_W'(s1_x_d[i]) * PROD_W'(act_leak_q);
        end
    end

    always_comb begin
        s2_valid_d = s1_valid_q;
        for (int unsigned i = 0; i < N_COLS; i++) begin
            lane_rnd[i]    = (s1_prod_q[i] + ROUND) >>> FRAC_W;
            lane_sat_hi[i] = lane_rnd[i] > MAX_Y;
            lane_sat_lo[i] = lane_rnd[i] < MIN_Y;
            lane_neg[i]    = s1_x_q[i][DATA_W-1];
            s2_data_d[i]   = s1_x_q[i];
            if (lane_neg[i] && s1_mode_q == MODE_RELU) begin
                s2_data_d[i] = '0;
            end else if (lane_neg[i] && s1_mode_q == MODE_LEAKY) begin
                if (lane_sat_hi[i])      s2_data_d[i] = MAX_Y[DATA_W-1:0];
                else if (lane_sat_lo[i]) s2_data_d[i] = MIN_Y[DATA_W-1:0];
                else                     s2_data_d[i] = lane_rnd[i][DATA_W-1:0];
            end
            if (!s1_valid_q[i]) s2_data_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_mode_q    <= MODE_RELU;
            act_leak_q    <= '0;
            shd_mode_q    <= MODE_RELU;
            shd_leak_q    <= '0;
            cfg_pending_q <= 1'b0;
            s1_valid_q    <= '0;
            s1_mode_q     <= MODE_RELU;
            s2_valid_q    <= '0;
            for (int unsigned i = 0; i < N_COLS; i++) begin
                s1_x_q[i]    <= '0;
                s1_prod_q[i] <= '0;
                s2_data_q[i] <= '0;
            end
        end else begin
            act_mode_q    <= act_mode_d;
            act_leak_q    <= act_leak_d;
            shd_mode_q    <= shd_mode_d;
            shd_leak_q    <= shd_leak_d;
            cfg_pending_q <= cfg_pending_d;
            s1_valid_q    <= s1_valid_d;
            s1_mode_q     <= s1_mode_d;
            s2_valid_q    <= s2_valid_d;
            for (int unsigned i = 0; i < N_COLS; i++) begin
                s1_x_q[i]    <= s1_x_d[i];
                s1_prod_q[i] <= s1_prod_d[i];
                s2_data_q[i] <= s2_data_d[i];
            end
        end
    end

    always_comb begin
        lr.lr_data_out = '0;
        for (int unsigned i = 0; i < N_COLS; i++) begin
            lr.lr_data_out[i*DATA_W +: DATA_W] = s2_data_q[i];
        end
    end

    assign lr.lr_ready_out       = ready;
    assign lr.lr_valid_out       = s2_valid_q;
    assign lr.lr_cfg_pending_out = cfg_pending_q;

`ifdef ACT_SAT_COUNT_EN
    logic [N_COLS-1:0] s2_sat_q, s2_sat_d;
    logic [31:0]       sat_cnt_q, sat_cnt_d;
    logic [32:0]       sat_sum;

    // Clamp flags travel with the beat; the counter adds them one edge later.
    always_comb begin
        for (int unsigned i = 0; i < N_COLS; i++) begin
            s2_sat_d[i] = s1_valid_q[i] && lane_neg[i] && (s1_mode_q == MODE_LEAKY)
                          && (lane_sat_hi[i] || lane_sat_lo[i]);
        end
        sat_sum = {1'b0, sat_cnt_q};
        for (int unsigned i = 0; i < N_COLS; i++) begin
            sat_sum = sat_sum + 33'(s2_sat_q[i]);
        end
        sat_cnt_d = sat_sum[32] ? '1 : sat_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_sat_q  <= '0;
            sat_cnt_q <= '0;
        end else begin
            s2_sat_q  <= s2_sat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign lr.lr_sat_count_out = sat_cnt_q;
`endif
endmodule
